anim_scheduler: RTL and testbench

//   Sequences the 7-segment animation engine. Generates single-cycle tick enables from clk,
//   not derived clocks: a scan tick for display multiplexing and a step tick for the

---
 rtl/anim_if.sv | 25 ++
 rtl/anim_scheduler.sv | 148 ++++++++++++++
 tb/tb_anim_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/anim_if.sv
// Board-side control inputs and animation-engine outputs of the scheduler.
// Signalling: btn_next is a one-cycle pulse, auto_en and pause are levels;
// scan_tick and step_tick are one-cycle enables, the rest are registered levels.
interface anim_if;
  logic       btn_next;
  logic       auto_en;
  logic       pause;
  logic       scan_tick;
  logic       step_tick;
  logic [1:0] anim_sel;
  logic       anim_restart;
  logic [7:0] frame_idx;

  // Board / test side: drives the controls, observes the schedule.
  modport master (
    output btn_next, auto_en, pause,
    input  scan_tick, step_tick, anim_sel, anim_restart, frame_idx
  );

  // Scheduler side.
  modport slave (
    input  btn_next, auto_en, pause,
    output scan_tick, step_tick, anim_sel, anim_restart, frame_idx
  );
endinterface

// File: rtl/anim_scheduler.sv
// Tick generator and animation selector for the 7-segment animation engine.
// scan_tick is a free-running multiplex enable; step_tick paces the selected
// animation and is gated by a RESTART/RUN/PAUSE state machine.
module anim_scheduler #(
  parameter int CNT_W   = 27,
  parameter int MUX_DIV = 16384,
  parameter int DIV0    = 33554432,
  parameter int DIV1    = 8388608,
  parameter int DIV2    = 16777216,
  parameter int FRAMES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  anim_if.slave      bus,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    ST_RESTART = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(MUX_DIV - 1);
  localparam logic [CNT_W-1:0] LAST0      = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] LAST1      = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] LAST2      = CNT_W'(DIV2 - 1);
  localparam logic [7:0]       FRAME_LAST = 8'(FRAMES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] scan_cnt;
  logic             scan_tick;
  logic [CNT_W-1:0] step_cnt;
  logic             step_tick;
  logic [7:0]       frame_idx;
  logic [1:0]       anim_sel;
  logic [CNT_W-1:0] step_last;
  logic             step_wrap;
  logic             auto_adv;
  logic             advance;
  logic             count_en;
  logic             anim_restart;

  // Step period of the currently selected animation (index 3 never occurs).
  always_comb begin
    step_last = LAST0;
    case (anim_sel)
      2'd1:    step_last = LAST1;
      2'd2:    step_last = LAST2;
      default: step_last = LAST0;
    endcase
  end

  assign step_wrap = (step_cnt == step_last);
  assign auto_adv  = bus.auto_en && step_wrap && (frame_idx == FRAME_LAST);

  // Advance decision: button wins in RUN and PAUSE; auto-advance only while running.
  always_comb begin
    advance = 1'b0;
    case (state)
      ST_RUN:   advance = bus.btn_next || auto_adv;
      ST_PAUSE: advance = bus.btn_next;
      default:  advance = 1'b0;
    endcase
  end

  // Scan prescaler: free-running, unaffected by pause and by the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
      scan_tick <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESTART;
    else     state <= state_next;
  end

  // FSM next-state logic; priority is advance over pause.
  always_comb begin
    state_next = state;
    case (state)
      ST_RESTART: state_next = bus.pause ? ST_PAUSE : ST_RUN;
      ST_RUN: begin
        if (advance)        state_next = ST_RESTART;
        else if (bus.pause) state_next = ST_PAUSE;
        else                state_next = ST_RUN;
      end
      ST_PAUSE: begin
        if (bus.btn_next)    state_next = ST_RESTART;
        else if (!bus.pause) state_next = ST_RUN;
        else                 state_next = ST_PAUSE;
      end
      default: state_next = ST_RESTART;
    endcase
  end

  // FSM outputs: restart flag, debug state, and the step counter enable.
  // A pause in RUN freezes the counter unless that cycle also advances, so a
  // step due on an advance edge is still issued.
  always_comb begin
    anim_restart = (state == ST_RESTART);
    fsm_state    = state;
    count_en     = (state == ST_RUN) && !(bus.pause && !advance);
  end

  // Step prescaler and frame counter.
  always_ff @(posedge clk) begin
    if (rst || state == ST_RESTART) begin
      step_cnt  <= '0;
      step_tick <= 1'b0;
      frame_idx <= '0;
    end else if (count_en) begin
      if (step_wrap) begin
        step_cnt  <= '0;
        step_tick <= 1'b1;
        frame_idx <= (frame_idx == FRAME_LAST) ? 8'd0 : frame_idx + 8'd1;
      end else begin
        step_cnt  <= step_cnt + 1'b1;
        step_tick <= 1'b0;
      end
    end else begin
      step_tick <= 1'b0;
    end
  end

  // Animation selector: 0 -> 1 -> 2 -> 0, one increment per advance edge.
  always_ff @(posedge clk) begin
    if (rst)          anim_sel <= 2'd0;
    else if (advance) anim_sel <= (anim_sel == 2'd2) ? 2'd0 : anim_sel + 2'd1;
  end

  assign bus.scan_tick    = scan_tick;
  assign bus.step_tick    = step_tick;
  assign bus.anim_sel     = anim_sel;
  assign bus.anim_restart = anim_restart;
  assign bus.frame_idx    = frame_idx;

endmodule

// File: tb/tb_anim_scheduler.sv
// Directed bench for anim_scheduler with small dividers
// (MUX_DIV=4, DIV0=5, DIV1=3, DIV2=4, FRAMES=2).
// Cycle k below means "just after the k-th rising edge following reset release".
module tb_anim_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;
  int         n_checks;
  int         n_errors;

  anim_if bus ();

  anim_scheduler #(
    .CNT_W   (27),
    .MUX_DIV (4),
    .DIV0    (5),
    .DIV1    (3),
    .DIV2    (4),
    .FRAMES  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step_clk();
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_restart"}, 32'(bus.anim_restart), 32'd1);
    check({tag, "_sel"},     32'(bus.anim_sel),     32'd0);
    check({tag, "_frame"},   32'(bus.frame_idx),    32'd0);
    check({tag, "_step"},    32'(bus.step_tick),    32'd0);
    check({tag, "_scan"},    32'(bus.scan_tick),    32'd0);
  endtask

  initial begin
    logic [1:0] exp_sel;
    logic [7:0] exp_frame;
    logic       exp_step;
    logic       exp_rst;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.btn_next = 1'b0;
    bus.auto_en  = 1'b0;
    bus.pause    = 1'b0;

    // 1. Reset held three cycles: restart asserted, everything cleared.
    for (int i = 0; i < 3; i++) begin
      step_clk();
      check_cleared("reset");
    end
    rst = 1'b0;
    #1;
    check("post_reset_restart", 32'(bus.anim_restart), 32'd1);

    // 2. No auto, no pause: scan every 4, step every 5 starting at cycle 6.
    for (int k = 1; k <= 100; k++) begin
      step_clk();
      exp_step  = (k >= 6) && ((k - 1) % 5 == 0);
      exp_frame = (k >= 6) ? 8'(((k - 1) / 5) % 2) : 8'd0;
      check("t2_sel", 32'(bus.anim_sel), 32'd0);
      if (k <= 40) begin
        check("t2_scan",    32'(bus.scan_tick),    32'((k % 4) == 0));
        check("t2_step",    32'(bus.step_tick),    32'(exp_step));
        check("t2_frame",   32'(bus.frame_idx),    32'(exp_frame));
        check("t2_restart", 32'(bus.anim_restart), 32'd0);
      end
    end

    // 3. Auto rotation: advances at 11 (sel1), 18 (sel2), 27 (sel0), 38 (sel1).
    do_reset();
    bus.auto_en = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      step_clk();
      exp_step = (k == 6) || (k == 11) || (k == 15) || (k == 18) ||
                 (k == 23) || (k == 27) || (k == 33) || (k == 38);
      exp_rst  = (k == 11) || (k == 18) || (k == 27) || (k == 38);
      if (k < 11)      exp_sel = 2'd0;
      else if (k < 18) exp_sel = 2'd1;
      else if (k < 27) exp_sel = 2'd2;
      else if (k < 38) exp_sel = 2'd0;
      else             exp_sel = 2'd1;
      check("t3_step",    32'(bus.step_tick),    32'(exp_step));
      check("t3_restart", 32'(bus.anim_restart), 32'(exp_rst));
      check("t3_sel",     32'(bus.anim_sel),     32'(exp_sel));
    end

    // 4. Two button presses reach sel 2; pause 10 cycles with cnt=2.
    bus.auto_en = 1'b0;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      bus.btn_next = (k == 2) || (k == 4);
      bus.pause    = (k >= 8) && (k <= 17);
      step_clk();
      if (k < 2)      exp_sel = 2'd0;
      else if (k < 4) exp_sel = 2'd1;
      else            exp_sel = 2'd2;
      check("t4_sel",     32'(bus.anim_sel),     32'(exp_sel));
      check("t4_restart", 32'(bus.anim_restart), 32'((k == 2) || (k == 4)));
      check("t4_step",    32'(bus.step_tick),    32'((k == 20) || (k == 24)));
      check("t4_scan",    32'(bus.scan_tick),    32'((k % 4) == 0));
      check("t4_frame",   32'(bus.frame_idx),    32'((k >= 20) && (k < 24)));
    end
    bus.btn_next = 1'b0;
    bus.pause    = 1'b0;

    // 5/6. Button with auto-advance (11), button while paused (14),
    //      then reset while sel=2, frame=1, cnt=3 (31).
    do_reset();
    bus.auto_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      bus.btn_next = (k == 11) || (k == 14);
      bus.pause    = (k >= 12) && (k <= 22);
      rst          = (k == 31);
      step_clk();
      if (k < 11)      exp_sel = 2'd0;
      else if (k < 14) exp_sel = 2'd1;
      else if (k < 31) exp_sel = 2'd2;
      else             exp_sel = 2'd0;
      if ((k >= 6 && k <= 10) || (k >= 27 && k <= 30)) exp_frame = 8'd1;
      else                                             exp_frame = 8'd0;
      check("t5_sel",     32'(bus.anim_sel),     32'(exp_sel));
      check("t5_restart", 32'(bus.anim_restart), 32'((k == 11) || (k == 14) || (k == 31)));
      check("t5_step",    32'(bus.step_tick),    32'((k == 6) || (k == 11) || (k == 27)));
      check("t5_frame",   32'(bus.frame_idx),    32'(exp_frame));
      check("t5_scan",    32'(bus.scan_tick),    32'((k % 4 == 0) && (k < 31)));
    end
    rst          = 1'b0;
    bus.btn_next = 1'b0;
    bus.pause    = 1'b0;
    bus.auto_en  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
